// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with saturation and leading-zero blanking
// ports: clk, rst_n (async active-low); start + numero request a conversion; busy high while iterating;
//        done pulses one cycle with a new result; digits = packed BCD, units in [3:0];
//        overflow = result saturated to all nines; blank[k] = digit k is a leading zero (bit 0 never set)
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   numero,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);
  // accumulator wide enough to hold any IN_WIDTH-bit value, even when fewer digits are displayed
  localparam int ID = (DIGITS > (IN_WIDTH + 2) / 3) ? DIGITS : (IN_WIDTH + 2) / 3;
  localparam int CW = $clog2(IN_WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] sh_q, sh_d, sh_n;
  logic [4*ID-1:0] acc_q, acc_d, adj, acc_n;
  logic [4*DIGITS-1:0] digits_q, digits_d, res;
  logic [DIGITS-1:0] blank_q, blank_d, bl;
  logic overflow_q, overflow_d, done_q, done_d, ovf, z;
  always_comb begin
    for (int k = 0; k < ID; k++)
      adj[4*k +: 4] = acc_q[4*k +: 4] >= 4'd5 ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    {acc_n, sh_n} = {adj[4*ID-2:0], sh_q, 1'b0};
    // anything above the displayed digits means the value does not fit: saturate to all nines
    ovf = |(acc_n >> (4 * DIGITS));
    res = ovf ? {DIGITS{4'h9}} : acc_n[4*DIGITS-1:0];
    // walk down from the top digit; blank stays set only while every digit so far is zero
    z = 1'b1;
    bl = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z = z & (res[4*k +: 4] == 4'd0);
      bl[k] = z;
    end
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    acc_d = acc_q;
    digits_d = digits_q;
    overflow_d = overflow_q;
    blank_d = blank_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        sh_d = numero;
        acc_d = '0;
        cnt_d = '0;
      end
    end else begin
      sh_d = sh_n;
      acc_d = acc_n;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(IN_WIDTH - 1)) begin
        state_d = IDLE;
        done_d = 1'b1;
        digits_d = res;
        overflow_d = ovf;
        blank_d = bl;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      acc_q <= '0;
      digits_q <= '0;
      overflow_q <= 1'b0;
      blank_q <= BLANK_RST;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      digits_q <= digits_d;
      overflow_q <= overflow_d;
      blank_q <= blank_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = done_q;
  assign digits = digits_q;
  assign overflow = overflow_q;
  assign blank = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: checks two-digit and three-digit converters side by side against constants and a decimal model
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] numero = '0;
  logic busy2, done2, ovf2, busy3, done3, ovf3;
  logic [7:0] dig2;
  logic [11:0] dig3;
  logic [1:0] bl2;
  logic [2:0] bl3;
  int nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .numero(numero),
    .busy(busy2), .done(done2), .digits(dig2), .overflow(ovf2), .blank(bl2)
  );
  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .numero(numero),
    .busy(busy3), .done(done3), .digits(dig3), .overflow(ovf3), .blank(bl3)
  );
  typedef struct {
    logic [7:0] n;
    logic [7:0] d2;
    logic o2;
    logic [1:0] b2;
    logic [11:0] d3;
    logic o3;
    logic [2:0] b3;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int pw10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction
  task automatic model(input int v, input int nd, output logic [11:0] d, output logic o, output logic [2:0] b);
    o = v >= pw10(nd);
    d = '0;
    b = '0;
    for (int k = 0; k < nd; k++) d[4*k +: 4] = o ? 4'd9 : 4'((v / pw10(k)) % 10);
    for (int k = 1; k < nd; k++) b[k] = !o && v < pw10(k);
  endtask
  task automatic conv(input vec_t e);
    int lat, nb;
    @(negedge clk);
    start = 1'b1;
    numero = e.n;
    @(negedge clk);
    start = 1'b0;
    numero = 8'($urandom);
    lat = 1;
    nb = 0;
    while (!done2 && lat < 30) begin
      if (busy2) nb++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency n=%0d", e.n), lat, 9);
    chk($sformatf("busy_cycles n=%0d", e.n), nb, 8);
    chk("busy_at_done", busy2, 0);
    chk("done3", done3, 1);
    chk($sformatf("digits2 n=%0d", e.n), dig2, e.d2);
    chk($sformatf("ovf2 n=%0d", e.n), ovf2, e.o2);
    chk($sformatf("blank2 n=%0d", e.n), bl2, e.b2);
    chk($sformatf("digits3 n=%0d", e.n), dig3, e.d3);
    chk($sformatf("ovf3 n=%0d", e.n), ovf3, e.o3);
    chk($sformatf("blank3 n=%0d", e.n), bl3, e.b3);
    @(negedge clk);
    chk("done_one_cycle", done2, 0);
    chk("digits_hold", dig2, e.d2);
  endtask
  initial begin
    vec_t r;
    logic [11:0] d;
    logic o;
    logic [2:0] b;
    int first, second, nd;
    tbl[0] = '{8'd45, 8'h45, 1'b0, 2'b00, 12'h045, 1'b0, 3'b100};
    tbl[1] = '{8'd7, 8'h07, 1'b0, 2'b10, 12'h007, 1'b0, 3'b110};
    tbl[2] = '{8'd0, 8'h00, 1'b0, 2'b10, 12'h000, 1'b0, 3'b110};
    tbl[3] = '{8'd99, 8'h99, 1'b0, 2'b00, 12'h099, 1'b0, 3'b100};
    tbl[4] = '{8'd100, 8'h99, 1'b1, 2'b00, 12'h100, 1'b0, 3'b000};
    tbl[5] = '{8'd255, 8'h99, 1'b1, 2'b00, 12'h255, 1'b0, 3'b000};
    tbl[6] = '{8'd9, 8'h09, 1'b0, 2'b10, 12'h009, 1'b0, 3'b110};
    tbl[7] = '{8'd10, 8'h10, 1'b0, 2'b00, 12'h010, 1'b0, 3'b100};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_digits2", dig2, 0);
    chk("rst_ovf2", ovf2, 0);
    chk("rst_blank2", bl2, 2'b10);
    chk("rst_blank3", bl3, 3'b110);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) conv(tbl[i]);
    for (int i = 0; i < 20; i++) begin
      r.n = 8'($urandom_range(0, 255));
      model(int'(r.n), 2, d, o, b);
      r.d2 = d[7:0];
      r.o2 = o;
      r.b2 = b[1:0];
      model(int'(r.n), 3, d, o, b);
      r.d3 = d;
      r.o3 = o;
      r.b3 = b;
      conv(r);
    end
    // start during a conversion must be ignored
    @(negedge clk);
    start = 1'b1;
    numero = 8'd45;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 1; i < 22; i++) begin
      if (done2) begin
        nd++;
        chk("ignore_digits", dig2, 8'h45);
        chk("ignore_when", i, 9);
      end
      start = (i == 3);
      numero = (i == 3) ? 8'd12 : numero;
      @(negedge clk);
    end
    chk("ignore_done_count", nd, 1);
    // back-to-back: start held through the done cycle
    start = 1'b1;
    numero = 8'd45;
    @(negedge clk);
    numero = 8'd67;
    first = -1;
    second = -1;
    nd = 0;
    for (int i = 1; i < 30; i++) begin
      if (done2) begin
        nd++;
        if (first < 0) begin
          first = i;
          chk("b2b_first", dig2, 8'h45);
        end else begin
          second = i;
          chk("b2b_second", dig2, 8'h67);
        end
      end
      if (first > 0 && i == first + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_first_at", first, 9);
    chk("b2b_gap", second - first, 9);
    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    numero = 8'd38;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy2, 0);
    chk("arst_done", done2, 0);
    chk("arst_digits2", dig2, 0);
    chk("arst_blank2", bl2, 2'b10);
    chk("arst_digits3", dig3, 0);
    chk("arst_blank3", bl3, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done2 || busy2) nd++;
      @(negedge clk);
    end
    chk("arst_no_done", nd, 0);
    r = '{8'd38, 8'h38, 1'b0, 2'b00, 12'h038, 1'b0, 3'b100};
    conv(r);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter. It is the next generation of the two-digit tens/units splitter used on the display path. It converts an IN_WIDTH-bit unsigned value into DIGITS packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake. It also provides saturation on overflow and a leading-zero blanking mask for the 7-segment drivers downstream.

Parameters:
IN_WIDTH, 8, width of the unsigned binary input (≥4).
DIGITS, 2, number of BCD digits presented at the output (≥1).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled on rising clk
numero  input  IN_WIDTH  unsigned binary value, captured on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: new result valid
digits  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0], digit k in [4k+3:4k]
overflow  output  1  last result exceeded 10^DIGITS−1 (output saturated)
blank  output  DIGITS  bit k=1: digit k is a leading zero (bit 0 always 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, digits=0, overflow=0, blank = all ones except bit 0 (i.e. display "0"). Bit counter and shift register cleared.
- Internal BCD accumulator is INT_DIGITS = max(DIGITS, ceil(IN_WIDTH/3)) digits wide, so a full conversion never loses bits.
- FSM has two states: IDLE and SHIFT.
- IDLE: if start=1 at a rising edge:
  - capture numero into the shift register and clear the accumulator and counter;
  - go to SHIFT; busy=1 from the next cycle.
  - If start=0, stay in IDLE.
- SHIFT: each edge performs one iteration:
  - every accumulator digit ≥5 gets +3;
  - then {accumulator, shift register} shifts left by 1;
  - counter increments.
- On the edge that completes iteration IN_WIDTH:
  - go to IDLE, busy=0, done=1 for exactly one cycle;
  - digits, overflow and blank update on this same edge.
- Latency: start sampled at edge E0 → done high in the cycle following edge E0+IN_WIDTH. busy is high during cycles E0+1 … E0+IN_WIDTH.
- Output update rules:
  - If any accumulator digit at index ≥DIGITS is nonzero: overflow=1, all DIGITS output digits =9, blank=0.
  - Otherwise: overflow=0, digits = low DIGITS accumulator digits.
  - blank[k]=1 for k≥1 iff digit k and all higher output digits are 0.
- digits, overflow and blank hold their value between completions. They never show intermediate iterations.
- start while busy=1 is ignored. No queueing; numero changes during SHIFT have no effect.
- start=1 in the done cycle is accepted, because the FSM is already in IDLE. This allows back-to-back conversions at a period of IN_WIDTH+1 cycles.
- Reset asserted mid-conversion aborts immediately: all outputs return to reset values and no done pulse is issued.
- done is never asserted when busy=1.

Test Plan:
- Defaults (IN_WIDTH=8, DIGITS=2): numero=45, start pulse → busy high 8 cycles; done pulse 8 cycles after the start edge; digits=8'h45, overflow=0, blank=2'b00.
- numero=7 → digits=8'h07, blank=2'b10. numero=0 → digits=8'h00, blank=2'b10. numero=99 → 8'h99, overflow=0.
- numero=100 and numero=255 (DIGITS=2) → digits=8'h99, overflow=1, blank=0. Re-run with DIGITS=3: 255 → 12'h255, overflow=0; 9 → 12'h009, blank=3'b110.
- start re-asserted at cycle 3 of a conversion with numero changed to 12 → ignored; result still matches the first operand; exactly one done pulse.
- Back-to-back: start held high through done (operands 45 then 67) → two done pulses 9 cycles apart; digits 8'h45 then 8'h67.
- rst_n pulsed low at iteration 4 of a conversion → busy=0, digits=0, blank=2'b10 asynchronously; no done pulse. A subsequent start converts correctly.
